// File: rtl/regfile_wb_arbiter_if.sv
// Write-back request channel: valid/ready handshake carrying a destination
// register and its value. The requester drives the master side.
interface regfile_wb_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 4
);
    logic          valid;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          ready;

    modport master (output valid, wa, wd, input ready);
    modport slave  (input valid, wa, wd, output ready);
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter (ALU vs load) for a 15-entry register file with
// PC redirect and pending-write scoreboard. Define WB_BYPASS_EN for in-flight bypass.
module regfile_wb_arbiter #(
    parameter int DW   = 32,
    parameter int AW   = 4,
    parameter int NREG = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wb_arbiter_if.slave  alu,
    regfile_wb_arbiter_if.slave  mem,
    input  logic                 iss_set,
    input  logic [AW-1:0]        iss_wa,
    input  logic [AW-1:0]        ra1,
    input  logic [AW-1:0]        ra2,
    output logic                 hazard,
    output logic [NREG-1:0]      busy,
    output logic                 we3,
    output logic [AW-1:0]        wa3,
    output logic [DW-1:0]        wd3,
    output logic                 pc_we,
    output logic [DW-1:0]        pc_wd,
    output logic                 byp1_hit,
    output logic                 byp2_hit,
    output logic [DW-1:0]        byp_data
);

    typedef enum logic {GNT_ALU = 1'b0, GNT_MEM = 1'b1} grant_e;

    localparam logic [AW-1:0] PC_ADDR = '1;
    localparam logic [AW-1:0] NREG_A  = AW'(NREG);

    grant_e          last_grant;
    logic            grant_alu;
    logic            grant_mem;
    logic            hs;
    logic            hs_pc;
    logic [AW-1:0]   sel_wa;
    logic [DW-1:0]   sel_wd;
    logic [NREG-1:0] busy_n;
    logic            src1_pend;
    logic            src2_pend;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        grant_alu = alu.valid && (!mem.valid || last_grant == GNT_MEM);
        grant_mem = mem.valid && !grant_alu;
        sel_wa    = grant_alu ? alu.wa : mem.wa;
        sel_wd    = grant_alu ? alu.wd : mem.wd;
        hs        = grant_alu || grant_mem;
        hs_pc     = hs && (sel_wa == PC_ADDR);
    end

    assign alu.ready = grant_alu;
    assign mem.ready = grant_mem;

    // Commit clears first, then issue sets, so a same-edge issue keeps the bit.
    always_comb begin
        busy_n = busy;
        if (we3 && wa3 < NREG_A)
            busy_n[wa3] = 1'b0;
        if (iss_set && iss_wa < NREG_A)
            busy_n[iss_wa] = 1'b1;
    end

    // NOTE: non-blocking assignments here so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we3        <= 1'b0;
            wa3        <= '0;
            wd3        <= '0;
            pc_we      <= 1'b0;
            pc_wd      <= '0;
            busy       <= '0;
            last_grant <= GNT_MEM;
        end else begin
            we3   <= hs && !hs_pc;
            pc_we <= hs_pc;
            busy  <= busy_n;
            if (hs && !hs_pc) begin
                wa3 <= sel_wa;
                wd3 <= sel_wd;
            end
            if (hs_pc)
                pc_wd <= sel_wd;
            if (hs)
                last_grant <= grant_alu ? GNT_ALU : GNT_MEM;
        end
    end

`ifdef WB_BYPASS_EN
    assign byp1_hit = we3 && (wa3 == ra1);
    assign byp2_hit = we3 && (wa3 == ra2);
    assign byp_data = wd3;
`else
    assign byp1_hit = 1'b0;
    assign byp2_hit = 1'b0;
    assign byp_data = '0;
`endif

    // A bypassed source is served from the in-flight value instead of stalling.
    assign src1_pend = (ra1 < NREG_A) && busy[ra1] && !byp1_hit;
    assign src2_pend = (ra2 < NREG_A) && busy[ra2] && !byp2_hit;
    assign hazard    = src1_pend || src2_pend;

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Write-back controller for the 15-entry, 32-bit, single-write-port register file.
- Arbitrates write-back between two requesters, the ALU and the memory-load unit, with a valid/ready handshake and round-robin priority.
- Drives the register file's we3/wa3/wd3 from a one-entry registered write-back stage.
- Keeps a pending-write scoreboard so decode can detect read-after-write hazards.
- Redirects writes to address 15 (r15, the PC) to a dedicated PC-write output; r15 is not held in the register file.

Parameters:
DW, 32, data width of write-back values.
AW, 4, register address width; address 4'hF is the PC.
NREG, 15, number of scoreboarded registers (addresses 0..14).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
alu_valid  in  1  ALU write-back request.
alu_wa  in  AW  ALU destination register.
alu_wd  in  DW  ALU result.
alu_ready  out  1  ALU request accepted this cycle.
mem_valid  in  1  load write-back request.
mem_wa  in  AW  load destination register.
mem_wd  in  DW  load data.
mem_ready  out  1  load request accepted this cycle.
iss_set  in  1  decode issues an instruction with a destination.
iss_wa  in  AW  destination of the issued instruction.
ra1  in  AW  decode read address 1.
ra2  in  AW  decode read address 2.
hazard  out  1  a source register has a pending write.
busy  out  NREG  scoreboard bits.
we3  out  1  register-file write enable.
wa3  out  AW  register-file write address.
wd3  out  DW  register-file write data.
pc_we  out  1  PC write strobe (write-back to r15).
pc_wd  out  DW  PC write data.
byp1_hit  out  1  ra1 matches the in-flight write (see optional feature).
byp2_hit  out  1  ra2 matches the in-flight write.
byp_data  out  DW  in-flight write data.

Behaviour:
Interface (already decided):
- One clock, clk.
- Reset rst_n is asynchronous and active-low.

Reset:
- we3, pc_we, busy, byp1_hit and byp2_hit are 0.
- wa3, wd3 and pc_wd are 0.
- Round-robin pointer last_grant = MEM, so the ALU wins the first tie.
- Asserting reset mid-operation discards any in-flight write and clears the scoreboard.

Arbitration (combinational, one grant per cycle):
- Only one requester valid: that requester is granted.
- Both valid: grant the side that is not last_grant; last_grant updates on every handshake.
- alu_ready/mem_ready go high only for the granted side. The other side holds valid, address and data stable until it is granted.
- Ready never depends on the write-back stage; the stage accepts a new write every cycle.

Write-back stage (registered, latency 1):
- Handshake at edge N and address != 15: we3=1 with wa3/wd3 during cycle N..N+1. The register file commits at edge N+1.
- Handshake at edge N and address == 15: pc_we=1, pc_wd=data for one cycle, we3=0.
- No handshake: we3=0 and pc_we=0. wa3/wd3 hold their last value.

Scoreboard:
- iss_set at an edge with iss_wa < 15 sets busy[iss_wa]. iss_wa == 15 is ignored.
- Commit edge (we3=1) clears busy[wa3].
- Set and clear of the same register at the same edge: set wins (a newer write is pending).
- A write to a non-busy register is legal; nothing changes.
- hazard (combinational) = (ra1 != 15 and busy[ra1]) or (ra2 != 15 and busy[ra2]).

Optional Feature:
WB_BYPASS_EN
- Defined:
  - byp1_hit = we3 and wa3 == ra1; byp2_hit likewise for ra2; byp_data = wd3.
  - hazard is suppressed for a source whose byp hit is 1. Decode takes byp_data instead of stalling.
- Undefined:
  - byp1_hit, byp2_hit and byp_data are tied to 0.
  - hazard follows the base rule; decode stalls until the commit edge clears busy.

Test Plan:
- Reset: release rst_n, no requests -> we3=0, pc_we=0, busy=0, hazard=0. Assert rst_n low mid-write -> we3 drops to 0 immediately, busy cleared.
- Single ALU write: alu_valid with wa=3, wd=32'hDEADBEEF -> alu_ready=1 that cycle; next cycle we3=1, wa3=3, wd3=32'hDEADBEEF; we3=0 the cycle after.
- Contention: both valid for 4 cycles (alu wa=1, mem wa=2, data updated on grant) -> grants in order ALU, MEM, ALU, MEM; the waiting side's payload stays stable while waiting.
- PC write: mem_valid with wa=15, wd=32'h100 -> pc_we=1, pc_wd=32'h100, we3=0, busy unchanged.
- Scoreboard: iss_set wa=5, then ra1=5 -> hazard=1. ALU write to 5 committed -> hazard=0 after the commit edge. Same-edge iss_set wa=5 with a commit to 5 -> busy[5] remains 1.
- Bypass (WB_BYPASS_EN defined): busy[7]=1 and in-flight write to 7 with wd=32'h55 -> byp1_hit=1, byp_data=32'h55, hazard=0. Without the macro -> byp1_hit=0, hazard=1.
